uart_stream_tx: RTL and testbench

- Parametrised successor to the fixed 8N1 FIFO-drain UART transmitter path.
- Pops bytes from a first-word-fall-through FIFO read port (same semantics as the project fifo: rdata valid while not empty, read-increment pops).
- Serialises bytes with configurable data bits, parity, stop bits and baud divider.
- Optional ASCII-hex mode with CR/LF inserted at end of frame, so Ethernet frames can be dumped to a terminal. Sits in the CLK48 domain after the CDC fifo.

---
 rtl/uart_stream_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_stream_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_tx.sv
// FIFO-drain UART transmitter: pops bytes from a first-word-fall-through FIFO and
// serialises them with configurable framing, optionally as ASCII hex with CR/LF at end of frame.
module uart_stream_tx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int HEX_MODE     = 0,
    parameter int EOF_NEWLINE  = 1
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic [7:0]  i_Fifo_Data,
    input  logic        i_Fifo_Eof,
    input  logic        i_Fifo_Empty,
    output logic        o_Fifo_Rd,
    input  logic        i_Pause,
    output logic        o_TX_Serial,
    output logic        o_TX_Active,
    output logic        o_Busy,
    output logic [15:0] o_Byte_Count
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]     DATA_MASK = 8'(255 >> (8 - DATA_BITS));
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_framing
            $error("uart_stream_tx: illegal framing parameters");
        end
        if (HEX_MODE != 0 && DATA_BITS < 7) begin : g_bad_hex
            $error("uart_stream_tx: HEX_MODE requires DATA_BITS >= 7");
        end
    endgenerate

    typedef enum logic [0:0] {F_IDLE, F_EMIT} f_state_t;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} s_state_t;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nib};
        end else begin
            hex_char = 8'h37 + {4'h0, nib};
        end
    endfunction

    function automatic logic parity_bit(input logic [7:0] c);
        parity_bit = (^(c & DATA_MASK)) ^ (PARITY == 1);
    endfunction

    function automatic logic line_level(input s_state_t s, input logic [2:0] bidx, input logic [7:0] c);
        case (s)
            S_IDLE:   line_level = 1'b1;
            S_START:  line_level = 1'b0;
            S_DATA:   line_level = c[bidx];
            S_PARITY: line_level = parity_bit(c);
            S_STOP:   line_level = 1'b1;
            default:  line_level = 1'b1;
        endcase
    endfunction

    f_state_t       f_q, f_d;
    s_state_t       s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [31:0]    chars_q, chars_d;
    logic [2:0]     nchar_q, nchar_d;
    logic [2:0]     idx_q, idx_d;
    logic           tx_q, tx_d;
    logic           active_q, active_d;
    logic           busy_q, busy_d;
    logic [15:0]    byte_count_q, byte_count_d;
    logic           rd_s, bit_end_s, char_end_s, more_s, pop_ok_s;
    logic [7:0]     cur_char_s;

    // Next-state logic for serializer, front end, pop strobe and registered line outputs
    always_comb begin
        f_d          = f_q;
        s_d          = s_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        chars_d      = chars_q;
        nchar_d      = nchar_q;
        idx_d        = idx_q;
        byte_count_d = byte_count_q;
        rd_s         = 1'b0;
        char_end_s   = 1'b0;
        pop_ok_s     = 1'b0;
        bit_end_s    = (cnt_q == CNT_LAST);
        more_s       = ((idx_q + 3'd1) < nchar_q);

        if (s_q == S_IDLE || bit_end_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        case (s_q)
            S_IDLE: begin
                // Idle with chars still queued means a pause is being honoured
                if (f_q == F_EMIT && !i_Pause) begin
                    s_d = S_START;
                end else begin
                    s_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    s_d   = S_DATA;
                    bit_d = 3'd0;
                end else begin
                    s_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s && bit_q == DATA_LAST) begin
                    s_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    bit_d = 3'd0;
                end else if (bit_end_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    s_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    s_d   = S_STOP;
                    bit_d = 3'd0;
                end else begin
                    s_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s && bit_q == STOP_LAST) begin
                    char_end_s = 1'b1;
                    if (more_s) begin
                        idx_d = idx_q + 3'd1;
                        s_d   = i_Pause ? S_IDLE : S_START;
                    end else begin
                        s_d = S_IDLE;
                    end
                end else if (bit_end_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    s_d = S_STOP;
                end
            end
            default: begin
                s_d = S_IDLE;
            end
        endcase

        case (f_q)
            F_IDLE: begin
                pop_ok_s = 1'b1;
            end
            F_EMIT: begin
                if (char_end_s && !more_s) begin
                    byte_count_d = byte_count_q + 16'd1;
                    f_d          = F_IDLE;
                    pop_ok_s     = 1'b1;
                end else begin
                    f_d = F_EMIT;
                end
            end
            default: begin
                f_d = F_IDLE;
            end
        endcase

        // A pop can land in the final stop-bit cycle so the next byte follows without a gap
        if (pop_ok_s && !i_Fifo_Empty && !i_Pause && i_Rst_n) begin
            rd_s  = 1'b1;
            f_d   = F_EMIT;
            s_d   = S_START;
            cnt_d = '0;
            bit_d = 3'd0;
            idx_d = 3'd0;
            if (HEX_MODE != 0) begin
                chars_d = {8'h0A, 8'h0D, hex_char(i_Fifo_Data[3:0]), hex_char(i_Fifo_Data[7:4])};
                nchar_d = (i_Fifo_Eof && EOF_NEWLINE != 0) ? 3'd4 : 3'd2;
            end else begin
                chars_d = {24'h000000, i_Fifo_Data};
                nchar_d = 3'd1;
            end
        end else begin
            rd_s = 1'b0;
        end

        cur_char_s = chars_d[{idx_d[1:0], 3'b000} +: 8];
        tx_d       = line_level(s_d, bit_d, cur_char_s);
        active_d   = (s_d != S_IDLE);
        busy_d     = (f_d == F_EMIT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            f_q          <= F_IDLE;
            s_q          <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            chars_q      <= 32'h0;
            nchar_q      <= 3'd0;
            idx_q        <= 3'd0;
            tx_q         <= 1'b1;
            active_q     <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            f_q          <= f_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            chars_q      <= chars_d;
            nchar_q      <= nchar_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            active_q     <= active_d;
            busy_q       <= busy_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign o_Fifo_Rd    = rd_s;
    assign o_TX_Serial  = tx_q;
    assign o_TX_Active  = active_q;
    assign o_Busy       = busy_q;
    assign o_Byte_Count = byte_count_q;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Directed bench for uart_stream_tx: three instances (raw 8N1, hex with CR/LF, 7E2)
// fed by small FIFO models; every line pattern is compared against hand-built frames.
module tb_uart_stream_tx;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        pause [3];
    logic [7:0]  fdata [3];
    logic        feof  [3];
    logic        fempty[3];
    logic        rd    [3];
    logic        ser   [3];
    logic        act   [3];
    logic        busy  [3];
    logic [15:0] bc    [3];

    logic [8:0]  fmem  [3][16];
    int          wptr  [3];
    int          rptr  [3];
    int          rdcnt [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        assign fempty[g] = (wptr[g] == rptr[g]);
        assign fdata[g]  = fmem[g][rptr[g][3:0]][7:0];
        assign feof[g]   = fmem[g][rptr[g][3:0]][8];
    end

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .HEX_MODE(0), .EOF_NEWLINE(1)) u_a (
        .i_Clock(clk), .i_Rst_n(rst_n[0]), .i_Fifo_Data(fdata[0]), .i_Fifo_Eof(feof[0]),
        .i_Fifo_Empty(fempty[0]), .o_Fifo_Rd(rd[0]), .i_Pause(pause[0]), .o_TX_Serial(ser[0]),
        .o_TX_Active(act[0]), .o_Busy(busy[0]), .o_Byte_Count(bc[0]));

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                     .HEX_MODE(1), .EOF_NEWLINE(1)) u_b (
        .i_Clock(clk), .i_Rst_n(rst_n[1]), .i_Fifo_Data(fdata[1]), .i_Fifo_Eof(feof[1]),
        .i_Fifo_Empty(fempty[1]), .o_Fifo_Rd(rd[1]), .i_Pause(pause[1]), .o_TX_Serial(ser[1]),
        .o_TX_Active(act[1]), .o_Busy(busy[1]), .o_Byte_Count(bc[1]));

    uart_stream_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                     .HEX_MODE(0), .EOF_NEWLINE(1)) u_c (
        .i_Clock(clk), .i_Rst_n(rst_n[2]), .i_Fifo_Data(fdata[2]), .i_Fifo_Eof(feof[2]),
        .i_Fifo_Empty(fempty[2]), .o_Fifo_Rd(rd[2]), .i_Pause(pause[2]), .o_TX_Serial(ser[2]),
        .o_TX_Active(act[2]), .o_Busy(busy[2]), .o_Byte_Count(bc[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // FIFO read side: a pop strobe advances the read pointer at the clock edge
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) begin
                rptr[i]  <= rptr[i] + 1;
                rdcnt[i] <= rdcnt[i] + 1;
            end
        end
    end

    // A pop strobe must never coincide with an empty FIFO
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) chk("rd_while_empty", 64'(fempty[i]), 64'd0);
        end
    end

    task automatic push(input int i, input logic [7:0] b, input logic e);
        fmem[i][wptr[i] % 16] = {e, b};
        wptr[i]++;
    endtask

    // Samples one whole character (4 clocks per bit) starting at the next falling edge
    task automatic expect_char(input int i, input logic [7:0] c, input int db, input bit has_par,
                               input logic pbit, input int sb, input string tag);
        logic [11:0] bits;
        logic [63:0] obs;
        logic [63:0] exp;
        logic        flags;
        int          nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int d = 0; d < db; d++) bits[1 + d] = c[d];
        nb = 1 + db;
        if (has_par) begin
            bits[nb] = pbit;
            nb++;
        end
        nb    = nb + sb;
        obs   = '0;
        exp   = '0;
        flags = 1'b1;
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                obs[b * 4 + t] = ser[i];
                exp[b * 4 + t] = bits[b];
                flags = flags & act[i] & busy[i];
            end
        end
        chk(tag, obs, exp);
        chk({tag, "_active_busy"}, 64'(flags), 64'd1);
    endtask

    task automatic chk_idle(input int i, input logic [15:0] cnt, input string tag);
        chk({tag, "_line"}, 64'(ser[i]), 64'd1);
        chk({tag, "_active"}, 64'(act[i]), 64'd0);
        chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
        chk({tag, "_count"}, 64'(bc[i]), 64'(cnt));
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            pause[i] = 1'b0;
            wptr[i]  = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_idle(i, 16'd0, "reset");
            chk("reset_rd", 64'(rd[i]), 64'd0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        // Raw 8N1, 0x55: alternating line, 40 cycles, one pop
        push(0, 8'h55, 1'b0);
        #1 chk("raw_rd_pulse", 64'(rd[0]), 64'd1);
        expect_char(0, 8'h55, 8, 1'b0, 1'b0, 1, "raw_55");
        @(negedge clk);
        chk_idle(0, 16'd1, "raw_done");
        chk("raw_rd_count", 64'(rdcnt[0]), 64'd1);

        // Hex with end-of-frame: 0xA7 -> 'A','7',CR,LF back-to-back
        push(1, 8'hA7, 1'b1);
        #1 chk("hex_rd_pulse", 64'(rd[1]), 64'd1);
        expect_char(1, 8'h41, 8, 1'b0, 1'b0, 1, "hex_A");
        expect_char(1, 8'h37, 8, 1'b0, 1'b0, 1, "hex_7");
        expect_char(1, 8'h0D, 8, 1'b0, 1'b0, 1, "hex_cr");
        chk("hex_count_before_lf", 64'(bc[1]), 64'd0);
        expect_char(1, 8'h0A, 8, 1'b0, 1'b0, 1, "hex_lf");
        @(negedge clk);
        chk_idle(1, 16'd1, "hex_done");
        chk("hex_rd_count", 64'(rdcnt[1]), 64'd1);

        // 7E2, three queued bytes; 0xF0 keeps only its low seven bits (0x70)
        push(2, 8'h07, 1'b0);
        push(2, 8'h12, 1'b0);
        push(2, 8'hF0, 1'b0);
        #1 chk("7e2_rd_pulse", 64'(rd[2]), 64'd1);
        expect_char(2, 8'h07, 7, 1'b1, 1'b1, 2, "7e2_07");
        expect_char(2, 8'h12, 7, 1'b1, 1'b0, 2, "7e2_12");
        expect_char(2, 8'h70, 7, 1'b1, 1'b1, 2, "7e2_70");
        @(negedge clk);
        chk_idle(2, 16'd3, "7e2_done");
        chk("7e2_rd_count", 64'(rdcnt[2]), 64'd3);

        // Pause raised during first hex char of 0x3C
        push(1, 8'h3C, 1'b0);
        #1 chk("pause_rd_pulse", 64'(rd[1]), 64'd1);
        @(posedge clk);
        #1 pause[1] = 1'b1;
        expect_char(1, 8'h33, 8, 1'b0, 1'b0, 1, "pause_3");
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            ok = ok & ser[1] & ~act[1] & busy[1];
        end
        chk("pause_hold", 64'(ok), 64'd1);
        pause[1] = 1'b0;
        expect_char(1, 8'h43, 8, 1'b0, 1'b0, 1, "pause_C");
        @(negedge clk);
        chk_idle(1, 16'd2, "pause_done");
        chk("pause_rd_count", 64'(rdcnt[1]), 64'd2);

        // Empty FIFO for 100 cycles: no pop, line idle
        ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = ok & ser[0] & ~rd[0];
        end
        chk("empty_quiet", 64'(ok), 64'd1);

        // Byte counter wrap from 65535
        force u_a.byte_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release u_a.byte_count_q;
        @(negedge clk);
        chk("wrap_preload", 64'(bc[0]), 64'hFFFF);
        push(0, 8'hA5, 1'b0);
        #1 chk("wrap_rd_pulse", 64'(rd[0]), 64'd1);
        expect_char(0, 8'hA5, 8, 1'b0, 1'b0, 1, "wrap_A5");
        @(negedge clk);
        chk_idle(0, 16'd0, "wrap_done");

        // Reset during a data bit abandons the character
        push(0, 8'h0F, 1'b0);
        #1 chk("rst_rd_pulse", 64'(rd[0]), 64'd1);
        repeat (10) @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk_idle(0, 16'd0, "rst_mid");
        rst_n[0] = 1'b1;
        @(negedge clk);
        push(0, 8'h3A, 1'b0);
        #1 chk("post_rst_rd_pulse", 64'(rd[0]), 64'd1);
        expect_char(0, 8'h3A, 8, 1'b0, 1'b0, 1, "post_rst_3A");
        @(negedge clk);
        chk_idle(0, 16'd1, "post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
